// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the logic-BIST sequencer
package bist_pkg;

    // Signature width of the MISR hf output and its expected value after a full session
    localparam int               BIST_SIG_W      = 12;
    localparam logic [BIST_SIG_W-1:0] BIST_GOLDEN_SIG = 12'hB76;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } bist_state_t;

endpackage

// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - one logic-BIST session: seed, run, freeze, compare, report
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int                 SIG_W      = BIST_SIG_W,
    parameter int                 N_PATTERNS = 1000,
    parameter int                 CNT_W      = 10,
    parameter int                 FLUSH_CYC  = 2,
    parameter logic [SIG_W-1:0]   GOLDEN_SIG = BIST_GOLDEN_SIG
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [SIG_W-1:0]  misr_sig,
    output logic              bist_rst,
    output logic              bist_end,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic [SIG_W-1:0]  sig_cap
);

    localparam int FL_W = $clog2(FLUSH_CYC + 1);

    bist_state_t       state_q, state_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic              bist_rst_d, bist_end_d, busy_d, done_d, pass_d, fail_d;
    logic [CNT_W-1:0]  pat_cnt_d;
    logic [SIG_W-1:0]  sig_cap_d;
    logic              sig_match;

    assign sig_match = (misr_sig == GOLDEN_SIG);

    // Next state and next registered outputs; outputs are computed for the state being entered
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        bist_rst_d  = 1'b0;
        bist_end_d  = 1'b1;
        busy_d      = busy;
        done_d      = done;
        pass_d      = pass;
        fail_d      = fail;
        pat_cnt_d   = pat_cnt;
        sig_cap_d   = sig_cap;

        if (abort) begin
            // pat_cnt and sig_cap are kept so the host can still inspect them
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d    = ST_INIT;
                        bist_rst_d = 1'b1;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        pass_d     = 1'b0;
                        fail_d     = 1'b0;
                        pat_cnt_d  = '0;
                    end
                end
                ST_INIT: begin
                    state_d    = ST_RUN;
                    bist_end_d = 1'b0;
                end
                ST_RUN: begin
                    if (pat_cnt != CNT_W'(N_PATTERNS)) begin
                        pat_cnt_d = pat_cnt + 1'b1;
                    end
                    // The final pattern is the one completing in this cycle
                    if (pat_cnt == CNT_W'(N_PATTERNS - 1)) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        bist_end_d = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // MISR hf lags its internal registers, so hold the freeze before sampling
                    if (flush_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
                        state_d = ST_COMPARE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    state_d   = ST_DONE;
                    sig_cap_d = misr_sig;
                    pass_d    = sig_match;
                    fail_d    = ~sig_match;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counters and all outputs registered; RST forces the reset values at once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            bist_rst    <= 1'b0;
            bist_end    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            pat_cnt     <= '0;
            sig_cap     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            bist_rst    <= bist_rst_d;
            bist_end    <= bist_end_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
            pat_cnt     <= pat_cnt_d;
            sig_cap     <= sig_cap_d;
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
// tb/tb_bist_sequencer.sv - scoreboard bench for bist_sequencer with directed sessions
module tb_bist_sequencer;

    localparam int SIG_W = 12;
    localparam int CNT_W = 3;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [SIG_W-1:0]  misr_sig = '0;
    logic              bist_rst, bist_end, busy, done, pass, fail;
    logic [CNT_W-1:0]  pat_cnt;
    logic [SIG_W-1:0]  sig_cap;

    int checks   = 0;
    int failures = 0;

    // Expected result per session: {pass, signature}
    logic [SIG_W:0] sb_q[$];
    logic           done_prev = 1'b0;

    bist_sequencer #(
        .SIG_W      (SIG_W),
        .N_PATTERNS (4),
        .CNT_W      (CNT_W),
        .FLUSH_CYC  (2),
        .GOLDEN_SIG (12'hB76)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .abort    (abort),
        .misr_sig (misr_sig),
        .bist_rst (bist_rst),
        .bist_end (bist_end),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .pat_cnt  (pat_cnt),
        .sig_cap  (sig_cap)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each reported result against the oldest queued expectation
    always @(negedge CLK) begin
        if (!RST) begin
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    logic [SIG_W:0] e;
                    e = sb_q.pop_front();
                    check("sb_sig_cap", 32'(sig_cap), 32'(e[SIG_W-1:0]));
                    check("sb_pass", 32'(pass), 32'(e[SIG_W]));
                    check("sb_fail", 32'(fail), 32'(!e[SIG_W]));
                end
            end
            check("inv_pass_fail_excl", 32'(pass & fail), 32'd0);
            check("inv_result_needs_done", 32'((pass | fail) & ~done), 32'd0);
        end
        done_prev = done;
    end

    // One session from IDLE or DONE; optional extra start at negedge index extra_at
    task automatic run_session(input logic [SIG_W-1:0] sig, input bit exp_pass, input int extra_at);
        int rst_cnt, end_low, hold_cnt, done_at;
        rst_cnt = 0; end_low = 0; hold_cnt = 0; done_at = 0;
        sb_q.push_back({exp_pass, sig});
        misr_sig = sig;
        start = 1'b1;
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            @(negedge CLK);
            start = (n == extra_at);
            if (n == 1) begin
                check("init_bist_rst", 32'(bist_rst), 32'd1);
                check("init_busy", 32'(busy), 32'd1);
                check("init_done_clear", 32'(done), 32'd0);
                check("init_pass_clear", 32'(pass), 32'd0);
                check("init_pat_cnt", 32'(pat_cnt), 32'd0);
            end
            if (bist_rst) rst_cnt++;
            if (!bist_end) end_low++;
            if (bist_end && busy && !bist_rst) hold_cnt++;
            if (done) done_at = n;
        end
        start = 1'b0;
        if (done_at == 0) check("done_timeout", 32'd0, 32'd1);
        check("bist_rst_pulses", 32'(rst_cnt), 32'd1);
        check("run_cycles", 32'(end_low), 32'd4);
        check("flush_compare_cycles", 32'(hold_cnt), 32'd3);
        // INIT, 4 RUN, 2 FLUSH, COMPARE, then done visible
        check("done_latency", 32'(done_at), 32'd9);
        check("pat_cnt_final", 32'(pat_cnt), 32'd4);
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset values
        @(negedge CLK);
        check("rst_bist_end", 32'(bist_end), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pat_cnt", 32'(pat_cnt), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Passing session, second start during RUN is ignored
        run_session(12'hB76, 1'b1, 0);
        run_session(12'hB76, 1'b1, 3);

        // Failing session started from DONE
        run_session(12'hB77, 1'b0, 0);

        // Mid-clock reset clears a held result before any clock edge
        #2 RST = 1'b1;
        #1;
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_fail", 32'(fail), 32'd0);
        check("async_rst_sig_cap", 32'(sig_cap), 32'd0);
        check("async_rst_pat_cnt", 32'(pat_cnt), 32'd0);
        check("async_rst_bist_end", 32'(bist_end), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Abort in RUN at pat_cnt=2
        misr_sig = 12'hB76;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_pre_cnt", 32'(pat_cnt), 32'd2);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bist_end", 32'(bist_end), 32'd1);
        check("abort_bist_rst", 32'(bist_rst), 32'd0);
        check("abort_pat_hold", 32'(pat_cnt), 32'd2);
        @(negedge CLK);
        run_session(12'hB76, 1'b1, 0);

        // abort and start together from DONE: abort wins
        abort = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_done", 32'(done), 32'd0);
        check("abort_start_pass", 32'(pass), 32'd0);
        check("abort_start_bist_rst", 32'(bist_rst), 32'd0);
        @(negedge CLK);
        check("abort_start_idle_busy", 32'(busy), 32'd0);
        check("abort_start_idle_rst", 32'(bist_rst), 32'd0);

        repeat (3) @(negedge CLK);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
